// File: rtl/sme_multi.sv
// sme_multi: buffers one string, then scans it against one pattern per
// transaction. Patterns support '^' (word start), '$' (word end) and '.'
// (any character). Each scan reports the first matching start position
// and the number of matching start positions.
module sme_multi #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_W-1:0]                chardata,
  input  logic                             isstring,
  input  logic                             ispattern,
  output logic                             busy,
  output logic                             valid,
  output logic                             match,
  output logic [$clog2(STR_DEPTH)-1:0]     match_index,
  output logic [$clog2(STR_DEPTH+1)-1:0]   match_count
);

  localparam int unsigned IW  = $clog2(STR_DEPTH);
  localparam int unsigned CW  = $clog2(STR_DEPTH + 1);
  localparam int unsigned PW  = $clog2(PAT_DEPTH + 1);
  localparam int unsigned PIW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;
  // Wide enough to hold pos + pattern length without wrapping.
  localparam int unsigned SW  = $clog2(STR_DEPTH + PAT_DEPTH + 1) + 1;

  localparam logic [DATA_W-1:0] CH_HAT   = DATA_W'(8'h5E);
  localparam logic [DATA_W-1:0] CH_DOL   = DATA_W'(8'h24);
  localparam logic [DATA_W-1:0] CH_DOT   = DATA_W'(8'h2E);
  localparam logic [DATA_W-1:0] CH_SPACE = DATA_W'(8'h20);

  typedef enum logic [1:0] {S_LOAD, S_SCAN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] str [STR_DEPTH];
  logic [DATA_W-1:0] pat [PAT_DEPTH];
  logic [CW-1:0]     len;
  logic [PW-1:0]     plen;
  logic              hat, dol;
  logic              pat_pend;   // at least one pattern char seen this transaction
  logic              str_fresh;  // next string char starts a new string
  logic [IW-1:0]     pos;
  logic              acc_match;
  logic [IW-1:0]     acc_index;
  logic [CW-1:0]     acc_count;

  logic              trigger, last, hit;
  logic [CW-1:0]     str_base;
  logic [PW-1:0]     pat_base;
  logic [SW-1:0]     pos_w, len_w, plen_w, end_w, idx;
  logic              fit, chars_ok, hat_ok, dol_ok;
  logic              nxt_match;
  logic [IW-1:0]     nxt_index;
  logic [CW-1:0]     nxt_count;

  assign busy  = (state != S_LOAD);
  assign valid = (state == S_DONE);

  // Load-side bookkeeping and scan-end detection.
  always_comb begin
    trigger  = (state == S_LOAD) && !isstring && !ispattern && pat_pend;
    str_base = str_fresh ? '0 : len;
    pat_base = pat_pend ? plen : '0;
    pos_w    = SW'(pos);
    len_w    = SW'(len);
    plen_w   = SW'(plen);
    end_w    = pos_w + plen_w;
    last     = (pos_w + SW'(1) == len_w);
  end

  // Match evaluation at start position pos; every str[] read is range-guarded.
  always_comb begin
    idx      = '0;
    fit      = (plen != '0) && (end_w <= len_w);
    chars_ok = 1'b1;
    for (int unsigned i = 0; i < PAT_DEPTH; i++) begin
      idx = pos_w + SW'(i);
      if ((SW'(i) < plen_w) && (pat[PIW'(i)] != CH_DOT)) begin
        if ((idx >= len_w) || (str[idx[IW-1:0]] != pat[PIW'(i)]))
          chars_ok = 1'b0;
      end
    end
    hat_ok = !hat || (pos == '0) || (str[pos - IW'(1)] == CH_SPACE);
    dol_ok = !dol || (end_w == len_w) ||
             ((end_w < len_w) && (str[end_w[IW-1:0]] == CH_SPACE));
    hit       = fit && chars_ok && hat_ok && dol_ok;
    nxt_match = acc_match | hit;
    nxt_index = (!acc_match && hit) ? pos : acc_index;
    nxt_count = acc_count + CW'(hit);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (trigger) state_nxt = (len == '0) ? S_DONE : S_SCAN;
      S_SCAN: if (last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // Character storage; contents need no reset since len/plen gate every read.
  always_ff @(posedge clk) begin
    if (!reset && state == S_LOAD) begin
      if (isstring && str_base < CW'(STR_DEPTH))
        str[str_base[IW-1:0]] <= chardata;
      if (ispattern && chardata != CH_HAT && chardata != CH_DOL &&
          pat_base < PW'(PAT_DEPTH))
        pat[pat_base[PIW-1:0]] <= chardata;
    end
  end

  // Lengths, flags, scan position, accumulators and held results.
  always_ff @(posedge clk) begin
    if (reset) begin
      len         <= '0;
      plen        <= '0;
      hat         <= 1'b0;
      dol         <= 1'b0;
      pat_pend    <= 1'b0;
      str_fresh   <= 1'b1;
      pos         <= '0;
      acc_match   <= 1'b0;
      acc_index   <= '0;
      acc_count   <= '0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (isstring) begin
            str_fresh <= 1'b0;
            len <= (str_base < CW'(STR_DEPTH)) ? str_base + CW'(1) : str_base;
          end else if (ispattern) begin
            // First pattern char of a transaction restarts from an empty pattern.
            pat_pend <= 1'b1;
            hat      <= (chardata == CH_HAT) | (pat_pend & hat);
            dol      <= (chardata == CH_DOL) | (pat_pend & dol);
            if (chardata != CH_HAT && chardata != CH_DOL && pat_base < PW'(PAT_DEPTH))
              plen <= pat_base + PW'(1);
            else
              plen <= pat_base;
          end
          if (trigger) begin
            pos       <= '0;
            acc_match <= 1'b0;
            acc_index <= '0;
            acc_count <= '0;
            if (len == '0) begin
              match       <= 1'b0;
              match_index <= '0;
              match_count <= '0;
            end
          end
        end
        S_SCAN: begin
          acc_match <= nxt_match;
          acc_index <= nxt_index;
          acc_count <= nxt_count;
          pos       <= pos + IW'(1);
          if (last) begin
            match       <= nxt_match;
            match_index <= nxt_index;
            match_count <= nxt_count;
          end
        end
        S_DONE: begin
          plen      <= '0;
          hat       <= 1'b0;
          dol       <= 1'b0;
          pat_pend  <= 1'b0;
          str_fresh <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
